// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, threshold flags and error pulses.
// Ports: clk, rst (sync, active-high); w_data/w_enable write side;
// r_enable/r_data read side; full, empty, almost_full, almost_empty,
// count, overflow, underflow status. Define SYNC_FIFO_FWFT_EN for
// first-word-fall-through reads; default is a registered r_data.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     w_enable,
  input  logic                     r_enable,
  output logic [WIDTH-1:0]         r_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // Flags decode the registered count only.
  always_comb begin
    full         = (count_q == CW'(DEPTH));
    empty        = (count_q == '0);
    almost_full  = (count_q >= CW'(AFULL_TH));
    almost_empty = (count_q <= CW'(AEMPTY_TH));
  end

  always_comb begin
    wr_acc  = w_enable && !full;
    rd_acc  = r_enable && !empty;
    wptr_d  = wptr_q + {{AW{1'b0}}, wr_acc};
    rptr_d  = rptr_q + {{AW{1'b0}}, rd_acc};
    count_d = count_q
            + {{AW{1'b0}}, wr_acc}
            - {{AW{1'b0}}, rd_acc};
    ovf_d   = w_enable && full;
    unf_d   = r_enable && empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not cleared by reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wptr_q[AW-1:0]] <= w_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign r_data = mem_q[rptr_q[AW-1:0]];
`else
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      rdata_q <= mem_q[rptr_q[AW-1:0]];
    end
  end

  assign r_data = rdata_q;
`endif

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (WIDTH=8, DEPTH=8, AFULL_TH=6,
// AEMPTY_TH=2); table of per-cycle vectors plus a held-overflow sequence.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] w_data;
  logic       w_enable;
  logic       r_enable;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int n_chk = 0;
  int n_fail = 0;

  sync_fifo_flags #(
    .WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .w_data(w_data), .w_enable(w_enable), .r_enable(r_enable),
    .r_data(r_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // rk: 0 no data check, 1 this cycle reads rx, 2 registered r_data holds rx
  typedef struct {
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] wd;
    int         cnt;
    logic       ovf;
    logic       unf;
    int         rk;
    logic [7:0] rx;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic we, logic re, logic [7:0] wd,
                              int cnt, logic ovf, logic unf,
                              int rk, logic [7:0] rx);
    vec_t v;
    v.rst = r; v.we = we; v.re = re; v.wd = wd; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.rk = rk; v.rx = rx;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, int idx, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_state(int idx, int cnt, logic ovf, logic unf);
    check("count", idx, int'(count), cnt);
    check("full", idx, int'(full), int'(cnt == 8));
    check("empty", idx, int'(empty), int'(cnt == 0));
    check("almost_full", idx, int'(almost_full), int'(cnt >= 6));
    check("almost_empty", idx, int'(almost_empty), int'(cnt <= 2));
    check("overflow", idx, int'(overflow), int'(ovf));
    check("underflow", idx, int'(underflow), int'(unf));
  endtask

  task automatic step(logic r, logic we, logic re, logic [7:0] wd);
    @(negedge clk);
    rst = r; w_enable = we; r_enable = re; w_data = wd;
  endtask

  initial begin
    rst = 1'b1; w_enable = 1'b0; r_enable = 1'b0; w_data = '0;

    add(1, 0, 0, 8'h00, 0, 0, 0, 2, 8'h00);
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'(i), i, 0, 0, 0, 0);
    add(0, 1, 0, 8'hAA, 8, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 8, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, 0, 1, 0, 8 - i, 0, 0, 1, 8'(i));
    add(0, 0, 1, 8'h00, 0, 0, 1, 2, 8'h08);
    add(0, 0, 0, 8'h00, 0, 0, 0, 2, 8'h08);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 8'(8'h10 + i), i + 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      add(0, 1, 1, 8'(8'h14 + i), 4, 0, 0, 1, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) add(0, 1, 0, 8'(8'h28 + i), 5 + i, 0, 0, 0, 0);
    add(0, 1, 1, 8'hBB, 7, 1, 0, 1, 8'h24);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 0, 6 - i, 0, 0, 1, 8'(8'h25 + i));
    add(0, 1, 1, 8'h30, 1, 0, 1, 2, 8'h2B);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 8'(8'h31 + i), 2 + i, 0, 0, 0, 0);
    add(1, 1, 0, 8'h55, 0, 0, 0, 2, 8'h00);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2, 8'h00);
    add(0, 1, 0, 8'h66, 1, 0, 0, 0, 0);
    add(0, 0, 1, 8'h00, 0, 0, 0, 1, 8'h66);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].wd);
`ifdef SYNC_FIFO_FWFT_EN
      #1;
      if (tbl[i].rk == 1) check("r_data", i, int'(r_data), int'(tbl[i].rx));
`endif
      @(posedge clk);
      #1;
      check_state(i, tbl[i].cnt, tbl[i].ovf, tbl[i].unf);
`ifndef SYNC_FIFO_FWFT_EN
      if (tbl[i].rk != 0) check("r_data", i, int'(r_data), int'(tbl[i].rx));
`endif
    end

    // Held write while full: overflow stays high each rejected cycle,
    // drops the cycle after w_enable is released.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'hC0 + i));
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 8'hEE);
      @(posedge clk);
      #1;
      check_state(1000 + i, 8, 1, 0);
    end
    step(0, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    check_state(1003, 8, 0, 0);
    step(0, 0, 1, 8'h00);
`ifdef SYNC_FIFO_FWFT_EN
    #1;
    check("r_data", 1004, int'(r_data), 32'hC0);
`endif
    @(posedge clk);
    #1;
    check_state(1004, 7, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("r_data", 1004, int'(r_data), 32'hC0);
`endif
    step(0, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
